key_operation: RTL and testbench

KEY_OPERATION -- requirements
Module: key_operation

---
 rtl/key_operation.sv | 113 +++++++++++
 tb/tb_key_operation.sv | 138 +++++++++++++
 2 files changed

// File: rtl/key_operation.sv
// Five-button front end: synchronize, debounce, press-edge detect, prioritize, auto-repeat directions.
// operation is one registered pulse D+3 edges after a clean press; busy masks output while trackers keep running.
module key_operation #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 15_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn,
  input  logic       busy,
  output logic [4:0] operation,
  output logic [4:0] key_level
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int RW = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST   = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] RPT_SAT    = RW'(RPT_MAX);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic [4:0]    sync1, sync2;
  logic [DW-1:0] db_cnt [5];
  logic [4:0]    level_q, press_q;

  state_t        state, state_n;
  logic [4:0]    track, track_n;
  logic [RW-1:0] rpt_cnt, rpt_cnt_n;
  logic [4:0]    cmd;
  logic          tracked_high;

  // Synchronizer, per-bit debounce and press-edge register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      key_level <= '0;
      level_q   <= '0;
      press_q   <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= key_level;
      press_q <= key_level & ~level_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == key_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] >= DB_LAST) begin
          key_level[i] <= sync2[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign tracked_high = |(track & key_level);

  // Tracker advances on internal commands even when busy hides them
  always_comb begin
    state_n   = state;
    track_n   = track;
    cmd       = '0;
    rpt_cnt_n = (rpt_cnt >= RPT_SAT) ? rpt_cnt : rpt_cnt + 1'b1;
    case (state)
      HOLD, REPEAT: begin
        if (!tracked_high) begin
          state_n   = IDLE;
          track_n   = '0;
          rpt_cnt_n = '0;
        end else if (rpt_cnt == ((state == HOLD) ? DELAY_LAST : PER_LAST)) begin
          cmd       = track;
          state_n   = REPEAT;
          rpt_cnt_n = '0;
        end
      end
      default: rpt_cnt_n = '0;
    endcase
    // Lowest set bit is the highest-priority press; it overrides any repeat due now
    if (|press_q) begin
      cmd       = press_q & (~press_q + 5'd1);
      rpt_cnt_n = '0;
      if (cmd[0]) begin
        state_n = IDLE;
        track_n = '0;
      end else begin
        state_n = HOLD;
        track_n = cmd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      track     <= '0;
      rpt_cnt   <= '0;
      operation <= '0;
    end else begin
      state     <= state_n;
      track     <= track_n;
      rpt_cnt   <= rpt_cnt_n;
      operation <= busy ? 5'b0 : cmd;
    end
  end

endmodule

// File: tb/tb_key_operation.sv
// Directed bench for key_operation with small timing parameters (debounce 4, delay 10, period 5).
// Edge 0 is the first rising edge after btn is applied; outputs are sampled 1ns after each edge.
module tb_key_operation;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic       busy;
  logic [4:0] operation;
  logic [4:0] key_level;

  int compared   = 0;
  int mismatched = 0;

  key_operation #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .busy     (busy),
    .operation(operation),
    .key_level(key_level)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of run, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst high just after an edge; caller drops rst and drives btn before edge 0
  task automatic do_reset();
    rst  = 1'b1;
    btn  = 5'b0;
    busy = 1'b0;
    repeat (3) tick();
  endtask

  logic [63:0] m;

  initial begin
    // Reset state
    do_reset();
    chk("reset_operation", operation, 5'b0);
    chk("reset_key_level", key_level, 5'b0);

    // Confirm held: single pulse at edge 7, no repeats
    rst = 1'b0; btn = 5'b00001;
    m = '0; m[7] = 1'b1;
    for (int e = 0; e < 25; e++) begin
      tick();
      chk($sformatf("confirm_op_e%0d", e), operation, m[e] ? 5'b00001 : 5'b0);
      if (e == 4) chk("confirm_level_e4", key_level, 5'b0);
      if (e == 5) chk("confirm_level_e5", key_level, 5'b00001);
    end

    // Three-cycle glitch on left never reaches the debounced level
    do_reset();
    rst = 1'b0; btn = 5'b00010;
    for (int e = 0; e < 15; e++) begin
      tick();
      if (e == 2) btn = 5'b0;
      chk($sformatf("glitch_op_e%0d", e), operation, 5'b0);
      chk($sformatf("glitch_level_e%0d", e), key_level, 5'b0);
    end

    // Up held 40 cycles: press at 7, first repeat at 17, then every 5, stop after release
    do_reset();
    rst = 1'b0; btn = 5'b01000;
    m = '0;
    m[7] = 1'b1; m[17] = 1'b1; m[22] = 1'b1; m[27] = 1'b1;
    m[32] = 1'b1; m[37] = 1'b1; m[42] = 1'b1;
    for (int e = 0; e < 60; e++) begin
      tick();
      chk($sformatf("repeat_op_e%0d", e), operation, m[e] ? 5'b01000 : 5'b0);
      if (e == 39) btn = 5'b0;
    end
    chk("repeat_level_released", key_level, 5'b0);

    // Confirm+right+down together: confirm wins, others discarded, no repeats
    do_reset();
    rst = 1'b0; btn = 5'b10101;
    m = '0; m[7] = 1'b1;
    for (int e = 0; e < 30; e++) begin
      tick();
      chk($sformatf("prio_op_e%0d", e), operation, m[e] ? 5'b00001 : 5'b0);
    end
    chk("prio_level", key_level, 5'b10101);

    // Right held with busy over edges 5..20: hidden press and first repeat, visible at 22, 27
    do_reset();
    rst = 1'b0; btn = 5'b00100;
    m = '0; m[22] = 1'b1; m[27] = 1'b1;
    for (int e = 0; e < 30; e++) begin
      tick();
      chk($sformatf("busy_op_e%0d", e), operation, m[e] ? 5'b00100 : 5'b0);
      if (e == 4)  busy = 1'b1;
      if (e == 20) busy = 1'b0;
    end

    // Down held, reset sampled at edge 12: repeat due at 17 is aborted; full debounce
    // restarts from the cleared synchronizer, giving the fresh press 8 edges after reset
    do_reset();
    rst = 1'b0; btn = 5'b10000;
    m = '0; m[7] = 1'b1; m[20] = 1'b1;
    for (int e = 0; e < 26; e++) begin
      tick();
      chk($sformatf("rst_op_e%0d", e), operation, m[e] ? 5'b10000 : 5'b0);
      if (e == 11) rst = 1'b1;
      if (e == 12) begin
        chk("rst_level_e12", key_level, 5'b0);
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
